output_buffer_ctrl: RTL and testbench

Ping-pong result buffer that sits between the systolic array's quantized output and the 64-bit AXI-Stream egress toward DMA. The compute side writes 128-bit result rows (16 lanes × int8) into the active write bank. A bank swap hands that bank to the drain engine, which serializes each row as two 64-bit beats, low half first, under full `tready` backpressure. It is the read-out counterpart of the weight buffer's 64→128 gearbox.

---
 rtl/obuf_pkg.sv | 21 ++
 rtl/obuf_bank_ram.sv | 33 +++
 rtl/output_buffer_ctrl.sv | 154 +++++++++++++++
 tb/tb_output_buffer_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obuf_pkg.sv
// ---------------------------------------------------------------------------
// obuf_pkg - shared widths and drain-state encoding for output_buffer_ctrl
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package obuf_pkg;
  localparam int ROW_W  = 128;
  localparam int AXIS_W = 64;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LO    = 2'd2,
    HI    = 2'd3
  } drain_state_t;
endpackage

`default_nettype wire

// File: rtl/obuf_bank_ram.sv
// ---------------------------------------------------------------------------
// obuf_bank_ram - simple dual-port RAM, one write port, 1-cycle registered read
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module obuf_bank_ram #(
  parameter int WIDTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on re, so rdata holds while a consumer stalls.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/output_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// output_buffer_ctrl - ping-pong 128-bit row buffer drained as 64-bit AXI-Stream
// rev 1.0; m_axis_tlast is driven only when OBUF_TLAST_EN is defined
// ---------------------------------------------------------------------------
`default_nettype none

module output_buffer_ctrl #(
  parameter int ROW_W  = obuf_pkg::ROW_W,
  parameter int AXIS_W = obuf_pkg::AXIS_W,
  parameter int DEPTH  = obuf_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  i_result_vec,
  input  logic              i_result_valid,
  input  logic              i_bank_swap,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              o_drain_busy,
  output logic              o_overflow,
  output logic              o_swap_err
);
  import obuf_pkg::*;

  localparam int PW = ADDR_W + 1;
`ifdef OBUF_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  drain_state_t      state;
  logic              wr_bank, rd_bank, go, more, pf_vld;
  logic [PW-1:0]     wr_ptr, rd_cnt, rd_idx, fin_cnt;
  logic [ROW_W-1:0]  row_q, pf_q, rdata, next_row;
  logic              wr_ok, idle, swap_ok, hs, re, rows_left;
  logic [PW-1:0]     raddr;

  // go covers the cycle between swap acceptance and FETCH, so it counts as busy.
  assign idle      = (state == IDLE) && !go;
  assign swap_ok   = i_bank_swap && idle;
  assign wr_ok     = i_result_valid && (wr_ptr < PW'(DEPTH));
  assign fin_cnt   = wr_ptr + PW'(wr_ok);
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign rows_left = rd_idx < rd_cnt;
  assign next_row  = pf_vld ? pf_q : rdata;

  always_comb begin
    re    = 1'b0;
    raddr = {rd_bank, rd_idx[ADDR_W-1:0]};
    if (go) begin
      re    = 1'b1;
      raddr = {rd_bank, {ADDR_W{1'b0}}};
    end else if (state == LO && hs && rows_left) begin
      re = 1'b1;
    end
  end

  obuf_bank_ram #(.WIDTH(ROW_W), .AW(PW)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr ({wr_bank, wr_ptr[ADDR_W-1:0]}),
    .wdata (i_result_vec),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_ptr     <= '0;
      rd_cnt     <= '0;
      o_overflow <= 1'b0;
      o_swap_err <= 1'b0;
    end else begin
      o_swap_err <= i_bank_swap && !idle;
      if (swap_ok) begin
        rd_bank    <= wr_bank;
        wr_bank    <= ~wr_bank;
        rd_cnt     <= fin_cnt;
        wr_ptr     <= '0;
        o_overflow <= 1'b0;
      end else if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end else if (i_result_valid) begin
        o_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      go            <= 1'b0;
      more          <= 1'b0;
      pf_vld        <= 1'b0;
      rd_idx        <= '0;
      row_q         <= '0;
      pf_q          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_drain_busy  <= 1'b0;
    end else begin
      go <= swap_ok && (fin_cnt != '0);
      case (state)
        IDLE: if (go) begin
          state        <= FETCH;
          o_drain_busy <= 1'b1;
          rd_idx       <= PW'(1);
        end
        FETCH: begin
          state         <= LO;
          row_q         <= rdata;
          m_axis_tdata  <= rdata[AXIS_W-1:0];
          m_axis_tvalid <= 1'b1;
        end
        LO: if (hs) begin
          state        <= HI;
          m_axis_tdata <= row_q[ROW_W-1:AXIS_W];
          m_axis_tlast <= TLAST_EN && !rows_left;
          more         <= rows_left;
          pf_vld       <= 1'b0;
          if (rows_left) rd_idx <= rd_idx + PW'(1);
        end
        HI: if (hs) begin
          pf_vld       <= 1'b0;
          m_axis_tlast <= 1'b0;
          if (more) begin
            state        <= LO;
            row_q        <= next_row;
            m_axis_tdata <= next_row[AXIS_W-1:0];
          end else begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
            o_drain_busy  <= 1'b0;
          end
        end else if (more && !pf_vld) begin
          pf_q   <= rdata;
          pf_vld <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_output_buffer_ctrl - directed/random bench with a queue-based buffer model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_output_buffer_ctrl;
`ifdef OBUF_TLAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] i_result_vec = '0;
  logic         i_result_valid = 1'b0;
  logic         i_bank_swap = 1'b0;
  logic [63:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic         o_drain_busy, o_overflow, o_swap_err;

  output_buffer_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_result_vec(i_result_vec), .i_result_valid(i_result_valid),
    .i_bank_swap(i_bank_swap),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .o_drain_busy(o_drain_busy), .o_overflow(o_overflow), .o_swap_err(o_swap_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: rows of the bank being written, overflow flag, expected beat stream.
  logic [127:0] wq[$];
  logic         movf = 1'b0;
  logic [63:0]  exp_d[$];
  logic         exp_l[$];
  logic [63:0]  got_d[$];
  logic         got_l[$];

  int ready_mode = 0;
  int pat = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // tready: 0 = always high, 1 = repeating 1-0-0-1, other = random
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = (pat == 0 || pat == 3);
        pat = (pat + 1) % 4;
      end
      default: m_axis_tready = ($urandom_range(0, 2) != 0);
    endcase
  end

  logic        stall = 1'b0;
  logic [63:0] sd;
  logic        sl;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("stall_tdata", m_axis_tdata, sd);
        check("stall_tlast", 64'(m_axis_tlast), 64'(sl));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
      stall = m_axis_tvalid && !m_axis_tready;
      sd    = m_axis_tdata;
      sl    = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [127:0] row);
    if (wq.size() < 64) wq.push_back(row);
    else movf = 1'b1;
  endtask

  task automatic write_row(input logic [127:0] row);
    i_result_vec   = row;
    i_result_valid = 1'b1;
    model_write(row);
    tick();
    i_result_valid = 1'b0;
  endtask

  task automatic write_rand(input int n);
    for (int i = 0; i < n; i++)
      write_row({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic do_swap(input bit with_row, input logic [127:0] row, input bit accept);
    i_bank_swap    = 1'b1;
    i_result_valid = with_row;
    i_result_vec   = row;
    if (with_row) model_write(row);
    if (accept) begin
      for (int i = 0; i < wq.size(); i++) begin
        logic [127:0] r;
        r = wq[i];
        exp_d.push_back(r[63:0]);   exp_l.push_back(1'b0);
        exp_d.push_back(r[127:64]); exp_l.push_back(TL && (i == wq.size() - 1));
      end
      wq.delete();
      movf = 1'b0;
    end
    tick();
    i_bank_swap    = 1'b0;
    i_result_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while (got_d.size() < exp_d.size() && cyc < 2000) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    check({tag, "_beats"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
    check({tag, "_busy_end"}, 64'(o_drain_busy), 64'd0);
    check({tag, "_tvalid_end"}, 64'(m_axis_tvalid), 64'd0);
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    logic [127:0] r0, r1;
    r0 = 128'h33333333_22222222_11111111_00000000;
    r1 = 128'h77777777_66666666_55555555_44444444;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_busy", 64'(o_drain_busy), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_swap_err", 64'(o_swap_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic drain with swap-to-first-beat latency
    ready_mode = 0;
    write_row(r0);
    write_row(r1);
    do_swap(1'b0, '0, 1'b1);
    check("lat_t0_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("lat_t0_busy", 64'(o_drain_busy), 64'd0);
    tick();
    check("lat_t1_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("lat_t1_busy", 64'(o_drain_busy), 64'd1);
    tick();
    check("lat_t2_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("lat_t2_tdata", m_axis_tdata, 64'h1111111100000000);
    wait_drain("basic");

    // backpressure 1-0-0-1
    ready_mode = 1;
    write_row(r0);
    write_row(r1);
    do_swap(1'b0, '0, 1'b1);
    wait_drain("bp");

    // ping-pong: fill the other bank while this one drains
    ready_mode = 2;
    write_rand(4);
    do_swap(1'b0, '0, 1'b1);
    write_rand(3);
    wait_drain("pp_a");
    do_swap(1'b0, '0, 1'b1);
    wait_drain("pp_b");

    // swap while busy is rejected
    ready_mode = 0;
    write_rand(4);
    do_swap(1'b0, '0, 1'b1);
    repeat (3) tick();
    i_bank_swap = 1'b1;
    tick();
    i_bank_swap = 1'b0;
    check("swap_err_pulse", 64'(o_swap_err), 64'd1);
    tick();
    check("swap_err_clear", 64'(o_swap_err), 64'd0);
    write_rand(2);
    wait_drain("busy_a");
    do_swap(1'b0, '0, 1'b1);
    wait_drain("busy_b");

    // overflow at exactly DEPTH rows
    ready_mode = 2;
    write_rand(64);
    check("ovf_at_64", 64'(o_overflow), 64'(movf));
    write_rand(1);
    check("ovf_at_65", 64'(o_overflow), 64'(movf));
    do_swap(1'b0, '0, 1'b1);
    check("ovf_cleared", 64'(o_overflow), 64'(movf));
    wait_drain("ovf");

    // random batches; final row written in the same cycle as the swap
    for (int it = 0; it < 4; it++) begin
      ready_mode = it % 3;
      write_rand($urandom_range(0, 5));
      do_swap(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      wait_drain($sformatf("rnd%0d", it));
    end

    // empty swap
    do_swap(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("empty_tvalid%0d", i), 64'(m_axis_tvalid), 64'd0);
      check($sformatf("empty_busy%0d", i), 64'(o_drain_busy), 64'd0);
      tick();
    end
    check("empty_beats", 64'(got_d.size()), 64'd0);

    // reset asserted while in HI of the only row
    ready_mode = 0;
    tick();
    write_row(r1);
    do_swap(1'b0, '0, 1'b1);
    repeat (3) tick();
    check("hi_tdata", m_axis_tdata, r1[127:64]);
    check("hi_tlast", 64'(m_axis_tlast), 64'(TL));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst_tdata", m_axis_tdata, 64'd0);
    check("arst_tlast", 64'(m_axis_tlast), 64'd0);
    check("arst_busy", 64'(o_drain_busy), 64'd0);
    check("arst_ovf", 64'(o_overflow), 64'd0);
    check("arst_swap_err", 64'(o_swap_err), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    wq.delete();
    movf = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
